rice_core_bypass_network: RTL

- Parametrised operand-forwarding unit for the rice core; successor to the fixed two-source forwarding stage.
- Sits between the ID-stage register-file read and the EX-stage operand muxes.
- Tracks the EX-stage result plus a configurable-depth history of retired results, and serves READ_PORTS source operands.
- Handles late results (loads whose value is not known in EX) by raising a load-use stall request and resolving the value one cycle later.
- Keeps performance counters for forwards and hazards.

---
 rtl/rice_core_bypass_network.sv | 121 ++++++++++++
 1 files changed

// File: rtl/rice_core_bypass_network.sv
// Operand-forwarding unit: forwards the EX result or one of DEPTH retired
// results to READ_PORTS source operands, and requests a stall on load-use.
module rice_core_bypass_network #(
  parameter int XLEN       = 32,
  parameter int READ_PORTS = 2,
  parameter int DEPTH      = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_enable,
  input  logic                       i_stall,
  input  logic                       i_flush,
  input  logic                       i_ex_valid,
  input  logic                       i_ex_error,
  input  logic                       i_ex_late,
  input  logic [4:0]                 i_ex_rd,
  input  logic [XLEN-1:0]            i_ex_rd_value,
  input  logic [XLEN-1:0]            i_late_value,
  input  logic [READ_PORTS*5-1:0]    i_rs,
  input  logic [READ_PORTS-1:0]      i_rs_used,
  input  logic [READ_PORTS*XLEN-1:0] i_rs_value,
  output logic [READ_PORTS*XLEN-1:0] o_rs_value,
  output logic                       o_stall_req,
  output logic [CNT_WIDTH-1:0]       o_fwd_count,
  output logic [CNT_WIDTH-1:0]       o_hazard_count
);

  logic [DEPTH-1:0]           h_vld_q, h_err_q, h_late_q;
  logic [DEPTH-1:0][4:0]      h_rd_q;
  logic [DEPTH-1:0][XLEN-1:0] h_val_q;
  logic [READ_PORTS-1:0]      stall_p, fwd_p;
  logic [CNT_WIDTH-1:0]       fwd_cnt_q, fwd_cnt_d, haz_cnt_q, haz_cnt_d;
  logic                       active;

  assign active = !i_rst && i_enable;

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
    logic [4:0]      rs;
    logic [XLEN-1:0] sel;
    logic            st, fw, hit;

    assign rs = i_rs[5*p +: 5];

    // Youngest source wins; a late EX hit blocks older entries for this port.
    always_comb begin
      sel = i_rs_value[XLEN*p +: XLEN];
      st  = 1'b0;
      fw  = 1'b0;
      hit = 1'b0;
      if (active && i_rs_used[p] && rs != 5'd0) begin
        if (i_ex_valid && !i_ex_error && i_ex_rd == rs) begin
          hit = 1'b1;
          if (i_ex_late) begin
            st = 1'b1;
          end else begin
            sel = i_ex_rd_value;
            fw  = 1'b1;
          end
        end
        for (int k = 0; k < DEPTH; k++) begin
          if (!hit && h_vld_q[k] && !h_err_q[k] && h_rd_q[k] == rs) begin
            hit = 1'b1;
            fw  = 1'b1;
            sel = h_late_q[k] ? i_late_value : h_val_q[k];
          end
        end
      end
    end

    assign o_rs_value[XLEN*p +: XLEN] = sel;
    assign stall_p[p] = st;
    assign fwd_p[p]   = fw;
  end

  assign o_stall_req = |stall_p;

  always_comb begin
    fwd_cnt_d = fwd_cnt_q;
    haz_cnt_d = haz_cnt_q;
    if (|fwd_p && fwd_cnt_q != '1) fwd_cnt_d = fwd_cnt_q + CNT_WIDTH'(1);
    if (o_stall_req && haz_cnt_q != '1) haz_cnt_d = haz_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_enable || i_flush) begin
      h_vld_q  <= '0;
      h_err_q  <= '0;
      h_late_q <= '0;
      h_rd_q   <= '0;
      h_val_q  <= '0;
      if (i_rst) begin
        fwd_cnt_q <= '0;
        haz_cnt_q <= '0;
      end
    end else if (!i_stall) begin
      h_vld_q[0]  <= i_ex_valid;
      h_err_q[0]  <= i_ex_error;
      h_late_q[0] <= i_ex_late;
      h_rd_q[0]   <= i_ex_rd;
      h_val_q[0]  <= i_ex_rd_value;
      for (int k = 1; k < DEPTH; k++) begin
        h_vld_q[k]  <= h_vld_q[k-1];
        h_err_q[k]  <= h_err_q[k-1];
        h_rd_q[k]   <= h_rd_q[k-1];
        // A late entry leaving stage 0 picks up its resolved value on the way.
        h_late_q[k] <= 1'b0;
        h_val_q[k]  <= (k == 1 && h_late_q[0]) ? i_late_value : h_val_q[k-1];
      end
      fwd_cnt_q <= fwd_cnt_d;
      haz_cnt_q <= haz_cnt_d;
    end else if (h_late_q[0]) begin
      h_val_q[0]  <= i_late_value;
      h_late_q[0] <= 1'b0;
    end
  end

  assign o_fwd_count    = fwd_cnt_q;
  assign o_hazard_count = haz_cnt_q;

endmodule
